// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising edges of spike_in over fixed-length windows.
// Optional minimum inter-spike interval tracking when SPIKE_RATE_DECODER_ISI_EN is defined.
module spike_rate_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [7:0]       window_len,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             sat_flag,
  output logic             above_thr,
  output logic [7:0]       isi_min
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic             spike_prev;
  logic             spike_det;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_inc;
  logic             sticky;
  logic             sat_now;
  logic [7:0]       win_cnt;
  logic [7:0]       win_len;
  logic             running;
  logic             win_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ena)  state_next = RUN;
      RUN:  if (!ena) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign spike_det = spike_in & ~spike_prev;
  assign running   = (state == RUN) && ena;
  assign win_end   = running && (win_cnt == win_len);
  // Saturating increment; a blocked increment marks the window as saturated.
  assign acc_inc   = (spike_det && acc != CNT_MAX) ? acc + 1'b1 : acc;
  assign sat_now   = sticky | (spike_det && acc == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_prev  <= 1'b0;
      acc         <= '0;
      sticky      <= 1'b0;
      win_cnt     <= 8'd0;
      win_len     <= 8'd0;
      count_out   <= '0;
      count_valid <= 1'b0;
      sat_flag    <= 1'b0;
      above_thr   <= 1'b0;
    end else begin
      spike_prev  <= spike_in;
      count_valid <= 1'b0;
      if (win_end) begin
        count_out   <= acc_inc;
        sat_flag    <= sat_now;
        above_thr   <= (acc_inc >= threshold);
        count_valid <= 1'b1;
        acc         <= '0;
        sticky      <= 1'b0;
        win_cnt     <= 8'd0;
        win_len     <= window_len;
      end else if (running) begin
        acc     <= acc_inc;
        sticky  <= sat_now;
        win_cnt <= win_cnt + 8'd1;
      end else begin
        // Idle (or ena just dropped): partial window is discarded.
        acc     <= '0;
        sticky  <= 1'b0;
        win_cnt <= 8'd0;
        win_len <= window_len;
      end
    end
  end

`ifdef SPIKE_RATE_DECODER_ISI_EN
  logic [7:0] isi_cnt;
  logic       isi_seen;
  logic [7:0] isi_run_min;
  logic [7:0] isi_min_cur;
  logic [7:0] isi_min_reg;

  // isi_cnt holds the cycle distance from the previous spike to the current cycle.
  assign isi_min_cur = (spike_det && isi_seen && isi_cnt < isi_run_min) ? isi_cnt : isi_run_min;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt     <= 8'd0;
      isi_seen    <= 1'b0;
      isi_run_min <= 8'hFF;
      isi_min_reg <= 8'hFF;
    end else if (win_end) begin
      isi_min_reg <= isi_min_cur;
      isi_cnt     <= 8'd0;
      isi_seen    <= 1'b0;
      isi_run_min <= 8'hFF;
    end else if (running) begin
      isi_run_min <= isi_min_cur;
      if (spike_det) begin
        isi_seen <= 1'b1;
        isi_cnt  <= 8'd1;
      end else if (isi_cnt != 8'hFF) begin
        isi_cnt <= isi_cnt + 8'd1;
      end
    end else begin
      isi_cnt     <= 8'd0;
      isi_seen    <= 1'b0;
      isi_run_min <= 8'hFF;
    end
  end

  assign isi_min = isi_min_reg;
`else
  assign isi_min = 8'hFF;
`endif

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of the spike accumulator, count_out and threshold.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: ena  input  1  run enable; low forces IDLE.
REQ-005 Port: spike_in  input  1  spike from the upstream spiking_neuron; same clock domain, no synchroniser.
REQ-006 Port: window_len  input  8  window length minus one, in clk cycles.
REQ-007 Port: threshold  input  CNT_W  rate threshold for above_thr.
REQ-008 Port: count_out  output  CNT_W  spike count of the last completed window.
REQ-009 Port: count_valid  output  1  one-cycle pulse when count_out updates.
REQ-010 Port: sat_flag  output  1  last completed window saturated the accumulator.
REQ-011 Port: above_thr  output  1  count_out >= threshold, registered with count_out.
REQ-012 Port: isi_min  output  8  minimum inter-spike interval of the last window (see Configuration).

Function
REQ-013 States: IDLE, RUN; IDLE->RUN on the first edge with ena=1; RUN->IDLE on any edge with ena=0.
REQ-014 A spike is the rising edge of spike_in (spike_in=1 and its registered previous value=0); a level held high counts once.
REQ-015 The previous-value register updates every cycle in both states, so an edge straddling IDLE->RUN is not lost or double-counted.
REQ-016 On entering RUN: window counter=0, accumulator=0, window_len sampled into a window-length register; window_len changes mid-window have no effect until the next window.
REQ-017 Each RUN cycle: accumulator increments by 1 on a detected spike, saturating at 2^CNT_W-1; a sticky saturation bit is set when an increment is blocked.
REQ-018 Window length = sampled window_len+1 cycles; window_len=0 gives one-cycle windows.
REQ-019 On the edge where the window counter equals the sampled length: count_out <= accumulator plus a spike detected that cycle (saturating); sat_flag <= sticky bit (including this cycle); above_thr <= (new count_out >= threshold); count_valid=1 for exactly that following cycle.
REQ-020 On that same edge: accumulator, sticky bit and window counter clear to 0, window_len resampled; the next window starts with no idle cycle.
REQ-021 In IDLE: accumulator, window counter and sticky bit held at 0; count_out, sat_flag, above_thr, isi_min hold their last values; count_valid=0.
REQ-022 ena dropping mid-window discards the partial window; no count_valid pulse.
REQ-023 threshold=0 makes above_thr=1 on every completed window.

Reset
REQ-024 rst_n low asynchronously forces: state=IDLE, count_out=0, count_valid=0, sat_flag=0, above_thr=0, isi_min=8'hFF, accumulator=0, window counter=0, previous-spike register=0.
REQ-025 Reset mid-window discards all partial state; no count_valid is emitted while or after reset until a full window completes.

Configuration
REQ-026 Macro SPIKE_RATE_DECODER_ISI_EN: when defined, an 8-bit interval counter (saturating at 255) counts cycles since the last spike in the current window and tracks the minimum interval between consecutive spikes; isi_min latches it at window end together with count_out.
REQ-027 With the macro defined, isi_min=8'hFF for windows with fewer than two spikes; the interval tracker clears at each window start, so intervals spanning windows are not measured.
REQ-028 Without the macro, the interval logic is absent and isi_min is constant 8'hFF.

Verification
REQ-029 window_len=9, ena=1, spike_in single-cycle pulses every 3 cycles from the RUN start -> count_valid every 10 cycles, count_out=4 in the first window (pulses at cycles 0,3,6,9); with ISI_EN isi_min=3.
REQ-030 CNT_W=8, window_len=255, spike_in toggling every cycle -> 128 edges, count_out=128, sat_flag=0; with CNT_W=4 -> count_out=15, sat_flag=1.
REQ-031 spike_in held high for 20 cycles inside one window, window_len=49 -> count_out=1.
REQ-032 ena dropped at cycle 5 of a 10-cycle window with 2 spikes, then re-raised -> no count_valid for the partial window; the next window counts from 0.
REQ-033 rst_n asserted asynchronously mid-window between clock edges -> all outputs at reset values immediately; isi_min=8'hFF.
REQ-034 threshold=3, windows with counts 2 then 3 -> above_thr=0 then 1, each aligned with its count_valid pulse.
